mc_ctrl_fsm: RTL and testbench

MC_CTRL_FSM -- requirements
Module: mc_ctrl_fsm

---
 rtl/mc_ctrl_fsm.sv | 271 +++++++++++++++++++++++++++
 tb/tb_mc_ctrl_fsm.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_ctrl_fsm.sv
// ---------------------------------------------------------------------------
// mc_ctrl_fsm
//   Main control FSM for a multicycle MIPS-style datapath. A Moore machine
//   walks each instruction through fetch, decode, address/execute,
//   memory and write-back steps and drives the datapath mux selects and
//   write enables for each step.
//
// Parameters
//   EXT_OPS   1: ANDI, ORI and BNE are decoded; 0: they trap as illegal.
//   MEM_HS    1: fetch and memory steps wait for mem_ready;
//             0: mem_ready is ignored and treated as always 1.
//
// Ports
//   clk        single clock, all state changes on its rising edge
//   reset      synchronous active-high reset
//   op         opcode field of the instruction register
//   mem_ready  memory access completes in the current cycle
//   iord, irwrite, pcwrite, branch, branch_ne, memwrite, regwrite,
//   regdst, memtoreg, alusrca, zeroext   datapath controls
//   alusrcb, pcsrc, aluop                datapath mux and ALU-class selects
//   illegal    high while a trapped opcode is being retired
//   retire     one-cycle pulse when an instruction completes
//   state      current state encoding, for debug
// ---------------------------------------------------------------------------
module mc_ctrl_fsm #(
  parameter int EXT_OPS = 1,
  parameter int MEM_HS  = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic       mem_ready,
  output logic       iord,
  output logic       irwrite,
  output logic       pcwrite,
  output logic       branch,
  output logic       branch_ne,
  output logic       memwrite,
  output logic       regwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       alusrca,
  output logic       zeroext,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [1:0] aluop,
  output logic       illegal,
  output logic       retire,
  output logic [3:0] state
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    EXECUTE = 4'd6,
    ALUWB   = 4'd7,
    BRANCH  = 4'd8,
    ADDIEX  = 4'd9,
    IMMWB   = 4'd10,
    JUMP    = 4'd11,
    IMMEX   = 4'd12,
    TRAP    = 4'd13
  } state_t;

  state_t     stateQ;
  state_t     nextState;
  state_t     targetState;
  logic [5:0] opLatched;
  logic       memReady;
  logic       extOn;

  // Registered copies of the per-state outputs, loaded with the values of
  // the state being entered so they change together with the state.
  logic       iordQ, branchQ, branchNeQ, memwriteQ, regwriteQ, regdstQ;
  logic       memtoregQ, alusrcaQ, zeroextQ, illegalQ, retireQ;
  logic       fetchQ, jumpQ, memwrQ;
  logic [1:0] alusrcbQ, pcsrcQ, aluopQ;

  logic       dIord, dBranch, dBranchNe, dMemwrite, dRegwrite, dRegdst;
  logic       dMemtoreg, dAlusrca, dZeroext, dIllegal, dRetire;
  logic       dFetch, dJump, dMemwr;
  logic [1:0] dAlusrcb, dPcsrc, dAluop;

  assign memReady = (MEM_HS != 0) ? mem_ready : 1'b1;
  assign extOn    = (EXT_OPS != 0);

  // Next-state logic. The decode split looks at the live opcode because
  // the latch is only written on that same edge; the MEMADR split looks
  // at the latched opcode so later changes on op cannot redirect it.
  // Unused encodings fall back to FETCH.
  always_comb begin
    nextState = stateQ;
    case (stateQ)
      FETCH:   if (memReady) nextState = DECODE;
      DECODE: begin
        case (op)
          OP_RTYPE:     nextState = EXECUTE;
          OP_LW, OP_SW: nextState = MEMADR;
          OP_BEQ:       nextState = BRANCH;
          OP_ADDI:      nextState = ADDIEX;
          OP_J:         nextState = JUMP;
          OP_BNE:       nextState = extOn ? BRANCH : TRAP;
          OP_ANDI,
          OP_ORI:       nextState = extOn ? IMMEX : TRAP;
          default:      nextState = TRAP;
        endcase
      end
      MEMADR:  nextState = (opLatched == OP_LW) ? MEMRD : MEMWR;
      MEMRD:   if (memReady) nextState = MEMWB;
      MEMWR:   if (memReady) nextState = FETCH;
      EXECUTE: nextState = ALUWB;
      ADDIEX:  nextState = IMMWB;
      IMMEX:   nextState = IMMWB;
      MEMWB, ALUWB, IMMWB, BRANCH, JUMP, TRAP: nextState = FETCH;
      default: nextState = FETCH;
    endcase
  end

  // The state actually loaded on the coming edge; reset always wins.
  always_comb begin
    targetState = reset ? FETCH : nextState;
  end

  // Output decode of the state being entered. BRANCH is only ever entered
  // from DECODE, so the live opcode is the one being latched on that edge.
  always_comb begin
    dIord     = 1'b0;
    dBranch   = 1'b0;
    dBranchNe = 1'b0;
    dMemwrite = 1'b0;
    dRegwrite = 1'b0;
    dRegdst   = 1'b0;
    dMemtoreg = 1'b0;
    dAlusrca  = 1'b0;
    dZeroext  = 1'b0;
    dIllegal  = 1'b0;
    dRetire   = 1'b0;
    dFetch    = 1'b0;
    dJump     = 1'b0;
    dMemwr    = 1'b0;
    dAlusrcb  = 2'b00;
    dPcsrc    = 2'b00;
    dAluop    = 2'b00;
    case (targetState)
      FETCH: begin
        dAlusrcb = 2'b01;
        dFetch   = 1'b1;
      end
      DECODE:  dAlusrcb = 2'b11;
      MEMADR, ADDIEX: begin
        dAlusrca = 1'b1;
        dAlusrcb = 2'b10;
      end
      MEMRD:   dIord = 1'b1;
      MEMWB: begin
        dMemtoreg = 1'b1;
        dRegwrite = 1'b1;
        dRetire   = 1'b1;
      end
      MEMWR: begin
        dIord     = 1'b1;
        dMemwrite = 1'b1;
        dMemwr    = 1'b1;
      end
      EXECUTE: begin
        dAlusrca = 1'b1;
        dAluop   = 2'b10;
      end
      ALUWB: begin
        dRegdst   = 1'b1;
        dRegwrite = 1'b1;
        dRetire   = 1'b1;
      end
      BRANCH: begin
        dAlusrca  = 1'b1;
        dAluop    = 2'b01;
        dPcsrc    = 2'b01;
        dBranch   = 1'b1;
        dBranchNe = (op == OP_BNE);
        dRetire   = 1'b1;
      end
      IMMEX: begin
        dAlusrca = 1'b1;
        dAlusrcb = 2'b10;
        dAluop   = 2'b11;
        dZeroext = 1'b1;
      end
      IMMWB: begin
        dRegwrite = 1'b1;
        dRetire   = 1'b1;
      end
      JUMP: begin
        dPcsrc  = 2'b10;
        dJump   = 1'b1;
        dRetire = 1'b1;
      end
      TRAP: begin
        dIllegal = 1'b1;
        dRetire  = 1'b1;
      end
      default: begin
        dIllegal = 1'b1;
        dRetire  = 1'b1;
      end
    endcase
  end

  // State register, opcode latch and registered outputs. The opcode is
  // captured on the edge that leaves DECODE and cleared by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      stateQ    <= FETCH;
      opLatched <= '0;
    end else begin
      stateQ <= nextState;
      if (stateQ == DECODE) opLatched <= op;
    end
    iordQ     <= dIord;
    branchQ   <= dBranch;
    branchNeQ <= dBranchNe;
    memwriteQ <= dMemwrite;
    regwriteQ <= dRegwrite;
    regdstQ   <= dRegdst;
    memtoregQ <= dMemtoreg;
    alusrcaQ  <= dAlusrca;
    zeroextQ  <= dZeroext;
    illegalQ  <= dIllegal;
    retireQ   <= dRetire;
    fetchQ    <= dFetch;
    jumpQ     <= dJump;
    memwrQ    <= dMemwr;
    alusrcbQ  <= dAlusrcb;
    pcsrcQ    <= dPcsrc;
    aluopQ    <= dAluop;
  end

  // Fetch enables and the store retire depend on mem_ready in the same
  // cycle; every side-effecting output is held low while reset is high.
  assign irwrite   = fetchQ & memReady & ~reset;
  assign pcwrite   = (jumpQ | (fetchQ & memReady)) & ~reset;
  assign memwrite  = memwriteQ & ~reset;
  assign regwrite  = regwriteQ & ~reset;
  assign branch    = branchQ & ~reset;
  assign illegal   = illegalQ & ~reset;
  assign retire    = (retireQ | (memwrQ & memReady)) & ~reset;
  assign iord      = iordQ;
  assign branch_ne = branchNeQ;
  assign regdst    = regdstQ;
  assign memtoreg  = memtoregQ;
  assign alusrca   = alusrcaQ;
  assign zeroext   = zeroextQ;
  assign alusrcb   = alusrcbQ;
  assign pcsrc     = pcsrcQ;
  assign aluop     = aluopQ;
  assign state     = stateQ;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// ---------------------------------------------------------------------------
// tb_mc_ctrl_fsm
//   Scoreboard bench for mc_ctrl_fsm. Three instances share the inputs:
//   index 0 is the default build, index 1 has EXT_OPS=0, index 2 has
//   MEM_HS=0. Each driven cycle pushes the hand-written expected state of
//   each instance plus its expected outputs; a monitor pops one entry per
//   cycle on the falling edge and compares.
// ---------------------------------------------------------------------------
module tb_mc_ctrl_fsm;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op;
  logic       mem_ready;

  logic       iord [3], irwrite [3], pcwrite [3], branch [3], branch_ne [3];
  logic       memwrite [3], regwrite [3], regdst [3], memtoreg [3];
  logic       alusrca [3], zeroext [3], illegal [3], retire [3];
  logic [1:0] alusrcb [3], pcsrc [3], aluop [3];
  logic [3:0] st [3];

  typedef struct {
    string       tag;
    int          sA;
    logic [18:0] oA;
    int          sB;
    logic [18:0] oB;
    int          sC;
    logic [18:0] oC;
  } exp_t;

  exp_t expQ[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : gDut
    mc_ctrl_fsm #(
      .EXT_OPS((g == 1) ? 0 : 1),
      .MEM_HS ((g == 2) ? 0 : 1)
    ) uDut (
      .clk      (clk),
      .reset    (reset),
      .op       (op),
      .mem_ready(mem_ready),
      .iord     (iord[g]),
      .irwrite  (irwrite[g]),
      .pcwrite  (pcwrite[g]),
      .branch   (branch[g]),
      .branch_ne(branch_ne[g]),
      .memwrite (memwrite[g]),
      .regwrite (regwrite[g]),
      .regdst   (regdst[g]),
      .memtoreg (memtoreg[g]),
      .alusrca  (alusrca[g]),
      .zeroext  (zeroext[g]),
      .alusrcb  (alusrcb[g]),
      .pcsrc    (pcsrc[g]),
      .aluop    (aluop[g]),
      .illegal  (illegal[g]),
      .retire   (retire[g]),
      .state    (st[g])
    );
  end

  // Reference table of outputs per state, taken from the state descriptions:
  // {iord,irwrite,pcwrite,branch,branch_ne,memwrite,regwrite,regdst,
  //  memtoreg,alusrca,zeroext,alusrcb,pcsrc,aluop,illegal,retire}
  function automatic logic [18:0] specOut(input logic [3:0] s, input logic mr,
                                          input logic bne, input logic rst);
    logic io, irw, pcw, br, brn, mw, rw, rd, m2r, asa, zx, ill, ret;
    logic [1:0] asb, pcs, aop;
    {io, irw, pcw, br, brn, mw, rw, rd, m2r, asa, zx, ill, ret} = '0;
    {asb, pcs, aop} = '0;
    case (s)
      4'd0:  begin asb = 2'b01; irw = mr; pcw = mr; end
      4'd1:  asb = 2'b11;
      4'd2,
      4'd9:  begin asa = 1; asb = 2'b10; end
      4'd3:  io = 1;
      4'd4:  begin m2r = 1; rw = 1; ret = 1; end
      4'd5:  begin io = 1; mw = 1; ret = mr; end
      4'd6:  begin asa = 1; aop = 2'b10; end
      4'd7:  begin rd = 1; rw = 1; ret = 1; end
      4'd8:  begin asa = 1; aop = 2'b01; pcs = 2'b01; br = 1; brn = bne; ret = 1; end
      4'd10: begin rw = 1; ret = 1; end
      4'd11: begin pcs = 2'b10; pcw = 1; ret = 1; end
      4'd12: begin asa = 1; asb = 2'b10; aop = 2'b11; zx = 1; end
      4'd13: begin ill = 1; ret = 1; end
      default: ;
    endcase
    if (rst) {irw, pcw, mw, rw, br, ret, ill} = '0;
    return {io, irw, pcw, br, brn, mw, rw, rd, m2r, asa, zx, asb, pcs, aop, ill, ret};
  endfunction

  // Drive one cycle of inputs just after the rising edge and queue the
  // expected state and outputs of each instance for that cycle (-1 = skip).
  task automatic applyStimulus(input string tag, input logic rst, input logic [5:0] opv,
                               input logic mr, input int sA, input logic bne,
                               input int sB, input int sC);
    exp_t e;
    @(posedge clk);
    #1;
    reset     = rst;
    op        = opv;
    mem_ready = mr;
    e.tag = tag;
    e.sA  = sA;
    e.oA  = specOut(sA[3:0], mr, bne, rst);
    e.sB  = sB;
    e.oB  = specOut(sB[3:0], mr, 1'b0, rst);
    e.sC  = sC;
    e.oC  = specOut(sC[3:0], 1'b1, bne, rst);
    expQ.push_back(e);
  endtask

  task automatic resetCycle();
    applyStimulus("reset", 1'b1, 6'b000000, 1'b1, -1, 1'b0, -1, -1);
  endtask

  // Compare one instance against its expected state and outputs.
  task automatic checkOutput(input string tag, input int idx, input int expSt,
                             input logic [18:0] expO);
    logic [18:0] act;
    if (expSt < 0) return;
    act = {iord[idx], irwrite[idx], pcwrite[idx], branch[idx], branch_ne[idx],
           memwrite[idx], regwrite[idx], regdst[idx], memtoreg[idx], alusrca[idx],
           zeroext[idx], alusrcb[idx], pcsrc[idx], aluop[idx], illegal[idx], retire[idx]};
    checks++;
    if (st[idx] !== expSt[3:0] || act !== expO) begin
      errors++;
      $display("[TB] FAIL %s dut%0d: state %0d outs %b, expected state %0d outs %b",
               tag, idx, st[idx], act, expSt, expO);
    end
  endtask

  // Monitor: one queued expectation per cycle, checked mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput(e.tag, 0, e.sA, e.oA);
        checkOutput(e.tag, 1, e.sB, e.oB);
        checkOutput(e.tag, 2, e.sC, e.oC);
      end
    end
  end

  initial begin
    reset     = 1'b1;
    op        = 6'b000000;
    mem_ready = 1'b1;
    repeat (2) @(posedge clk);

    // LW, no stalls: 0,1,2,3,4,0; op changed after decode
    resetCycle();
    applyStimulus("lw",  0, 6'b100011, 1, 0, 0, 0, 0);
    applyStimulus("lw",  0, 6'b100011, 1, 1, 0, 1, 1);
    applyStimulus("lw",  0, 6'b101011, 1, 2, 0, 2, 2);
    applyStimulus("lw",  0, 6'b000000, 1, 3, 0, 3, 3);
    applyStimulus("lw",  0, 6'b000000, 1, 4, 0, 4, 4);
    applyStimulus("lw",  0, 6'b000000, 1, 0, 0, 0, 0);

    // SW with two stalled MEMWR cycles; op changed to LW after decode
    resetCycle();
    applyStimulus("sw",  0, 6'b101011, 1, 0, 0, 0, -1);
    applyStimulus("sw",  0, 6'b101011, 1, 1, 0, 1, -1);
    applyStimulus("sw",  0, 6'b100011, 1, 2, 0, 2, -1);
    applyStimulus("sw",  0, 6'b100011, 0, 5, 0, 5, -1);
    applyStimulus("sw",  0, 6'b100011, 0, 5, 0, 5, -1);
    applyStimulus("sw",  0, 6'b100011, 1, 5, 0, 5, -1);
    applyStimulus("sw",  0, 6'b100011, 1, 0, 0, 0, -1);

    // BNE: branch on default build, trap with EXT_OPS=0
    resetCycle();
    applyStimulus("bne", 0, 6'b000101, 1, 0, 0, 0, 0);
    applyStimulus("bne", 0, 6'b000101, 1, 1, 0, 1, 1);
    applyStimulus("bne", 0, 6'b000100, 1, 8, 1, 13, 8);
    applyStimulus("bne", 0, 6'b000100, 1, 0, 0, 0, 0);

    // BEQ: op changed to BNE after decode must not raise branch_ne
    resetCycle();
    applyStimulus("beq", 0, 6'b000100, 1, 0, 0, 0, 0);
    applyStimulus("beq", 0, 6'b000100, 1, 1, 0, 1, 1);
    applyStimulus("beq", 0, 6'b000101, 1, 8, 0, 8, 8);
    applyStimulus("beq", 0, 6'b000101, 1, 0, 0, 0, 0);

    // ORI: 0,1,12,10,0; traps with EXT_OPS=0
    resetCycle();
    applyStimulus("ori", 0, 6'b001101, 1, 0, 0, 0, 0);
    applyStimulus("ori", 0, 6'b001101, 1, 1, 0, 1, 1);
    applyStimulus("ori", 0, 6'b001101, 1, 12, 0, 13, 12);
    applyStimulus("ori", 0, 6'b001101, 1, 10, 0, 0, 10);
    applyStimulus("ori", 0, 6'b001101, 1, 0, 0, 1, 0);

    // ANDI, ADDI, R-type, illegal opcode
    resetCycle();
    applyStimulus("andi", 0, 6'b001100, 1, 0, 0, -1, 0);
    applyStimulus("andi", 0, 6'b001100, 1, 1, 0, -1, 1);
    applyStimulus("andi", 0, 6'b001100, 1, 12, 0, -1, 12);
    applyStimulus("andi", 0, 6'b001100, 1, 10, 0, -1, 10);
    applyStimulus("andi", 0, 6'b001100, 1, 0, 0, -1, 0);
    resetCycle();
    applyStimulus("addi", 0, 6'b001000, 1, 0, 0, 0, 0);
    applyStimulus("addi", 0, 6'b001000, 1, 1, 0, 1, 1);
    applyStimulus("addi", 0, 6'b001000, 1, 9, 0, 9, 9);
    applyStimulus("addi", 0, 6'b001000, 1, 10, 0, 10, 10);
    applyStimulus("addi", 0, 6'b001000, 1, 0, 0, 0, 0);
    resetCycle();
    applyStimulus("rtype", 0, 6'b000000, 1, 0, 0, 0, 0);
    applyStimulus("rtype", 0, 6'b000000, 1, 1, 0, 1, 1);
    applyStimulus("rtype", 0, 6'b000000, 1, 6, 0, 6, 6);
    applyStimulus("rtype", 0, 6'b000000, 1, 7, 0, 7, 7);
    applyStimulus("rtype", 0, 6'b000000, 1, 0, 0, 0, 0);
    resetCycle();
    applyStimulus("illop", 0, 6'b111111, 1, 0, 0, 0, 0);
    applyStimulus("illop", 0, 6'b111111, 1, 1, 0, 1, 1);
    applyStimulus("illop", 0, 6'b111111, 1, 13, 0, 13, 13);
    applyStimulus("illop", 0, 6'b111111, 1, 0, 0, 0, 0);

    // FETCH stalled 3 cycles then J; MEM_HS=0 ignores the stall
    resetCycle();
    applyStimulus("fstall", 0, 6'b000010, 0, 0, 0, 0, 0);
    applyStimulus("fstall", 0, 6'b000010, 0, 0, 0, 0, 1);
    applyStimulus("fstall", 0, 6'b000010, 0, 0, 0, 0, 11);
    applyStimulus("fstall", 0, 6'b000010, 1, 0, 0, 0, 0);
    applyStimulus("fstall", 0, 6'b000010, 1, 1, 0, 1, 1);
    applyStimulus("fstall", 0, 6'b000010, 1, 11, 0, 11, 11);
    applyStimulus("fstall", 0, 6'b000010, 1, 0, 0, 0, 0);

    // LW with one stalled MEMRD cycle
    resetCycle();
    applyStimulus("rstall", 0, 6'b100011, 1, 0, 0, 0, -1);
    applyStimulus("rstall", 0, 6'b100011, 1, 1, 0, 1, -1);
    applyStimulus("rstall", 0, 6'b100011, 1, 2, 0, 2, -1);
    applyStimulus("rstall", 0, 6'b100011, 0, 3, 0, 3, -1);
    applyStimulus("rstall", 0, 6'b100011, 1, 3, 0, 3, -1);
    applyStimulus("rstall", 0, 6'b100011, 1, 4, 0, 4, -1);
    applyStimulus("rstall", 0, 6'b100011, 1, 0, 0, 0, -1);

    // Reset during EXECUTE: no ALUWB, straight back to FETCH
    resetCycle();
    applyStimulus("rstexe", 0, 6'b000000, 1, 0, 0, 0, 0);
    applyStimulus("rstexe", 0, 6'b000000, 1, 1, 0, 1, 1);
    applyStimulus("rstexe", 1, 6'b000000, 1, 6, 0, 6, 6);
    applyStimulus("rstexe", 0, 6'b000000, 1, 0, 0, 0, 0);
    applyStimulus("rstexe", 0, 6'b000000, 1, 1, 0, 1, 1);

    // Reset during a completing MEMWR: memwrite and retire held low
    resetCycle();
    applyStimulus("rstmw", 0, 6'b101011, 1, 0, 0, 0, 0);
    applyStimulus("rstmw", 0, 6'b101011, 1, 1, 0, 1, 1);
    applyStimulus("rstmw", 0, 6'b101011, 1, 2, 0, 2, 2);
    applyStimulus("rstmw", 1, 6'b101011, 1, 5, 0, 5, 5);
    applyStimulus("rstmw", 0, 6'b101011, 1, 0, 0, 0, 0);

    repeat (3) @(negedge clk);
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain: %0d entries left, expected 0", expQ.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
